// File: rtl/ram_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_arb_pkg
//  Description : Shared helpers for the RAM round-robin arbiter.
//                onehot_to_idx - one-hot vector (up to 8 bits) to binary index
//                rr_pick       - round-robin pick: first set request found
//                                after the pointer, wrapping, as one-hot
//  Revision    : 1.0 - initial release
// ============================================================================
package ram_arb_pkg;

    localparam int c_max_req = 8;

    // All inputs are zero-extended to 8 bits by the caller. The OR-merge
    // gives the exact index for a true one-hot vector and 0 for all-zero.
    function automatic logic [2:0] onehot_to_idx(input logic [7:0] oh);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < c_max_req; i++) begin
            if (oh[i]) begin
                idx = idx | 3'(i);
            end
        end
        return idx;
    endfunction

    // Scan order is ptr+1, ptr+2, ... wrapping modulo n, so the requester
    // granted last has the lowest priority on the next pick.
    function automatic logic [7:0] rr_pick(input logic [7:0] req,
                                           input logic [2:0] ptr,
                                           input int         n);
        logic [7:0] gnt;
        logic       found;
        logic [2:0] idx;
        gnt   = 8'd0;
        found = 1'b0;
        for (int k = 1; k <= c_max_req; k++) begin
            if (k <= n) begin
                idx = 3'((int'(ptr) + k) % n);
                if (!found && req[idx]) begin
                    gnt[idx] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
        return gnt;
    endfunction

endpackage : ram_arb_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arbiter
//  Description : Generic N-way round-robin arbiter (N = 1..8). Combinational
//                one-hot grant; the pointer register remembers the last
//                granted index and only moves on a grant.
//  Ports       : clk       - clock
//                rst_n     - asynchronous active-low reset (ptr <= N-1)
//                req       - request vector
//                grant     - one-hot grant (combinational)
//                grant_idx - binary index of grant (0 when no grant)
//                ptr       - last-grant pointer
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx,
    output logic [IW-1:0] ptr
);

    logic [IW-1:0] r_ptr;
    logic [7:0]    w_req8;
    logic [7:0]    w_gnt8;
    logic [2:0]    w_idx3;
    logic          w_unused_bits;

    assign w_req8    = 8'(req);
    assign w_gnt8    = rr_pick(w_req8, 3'(r_ptr), N);
    assign w_idx3    = onehot_to_idx(w_gnt8);
    assign grant     = w_gnt8[N-1:0];
    assign grant_idx = IW'(w_idx3);
    assign ptr       = r_ptr;

    // Upper bits of the 8-bit helper results are constant zero for N < 8.
    assign w_unused_bits = ^{w_gnt8, w_idx3};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= IW'(N - 1);
        end else if (|grant) begin
            r_ptr <= grant_idx;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/ram_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : ram_rr_arbiter
//  Description : Shares one single-port, read-first RAM with 1-cycle
//                registered read between NREQ requesters. Round-robin grant,
//                RAM driven in the grant cycle, one-cycle read-response strobe
//                per requester in the following cycle.
//  Macro       : RAMARB_PRIO0_EN - when defined, requester 0 is granted
//                whenever it is valid (pointer untouched) and requesters
//                1..NREQ-1 round-robin among themselves.
//  Ports       : clk, rst_n             - clock, async active-low reset
//                req_valid/req_ready    - per-requester handshake
//                req_we/req_addr/req_wdata - packed request payloads
//                rsp_valid/rsp_rdata    - one-hot read strobe and data
//                ram_addr/ram_we/ram_din/ram_qout - RAM interface
//  Revision    : 1.0 - initial release
// ============================================================================
module ram_rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int NREQ  = 2,
    parameter  int DW    = 8,
    parameter  int WORDS = 256,
    localparam int AW    = $clog2(WORDS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ-1:0]   req_we,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic [AW-1:0]     ram_addr,
    output logic              ram_we,
    output logic [DW-1:0]     ram_din,
    input  logic [DW-1:0]     ram_qout
);

    localparam int c_iw = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [NREQ-1:0] w_arb_req;
    logic [NREQ-1:0] w_arb_grant;
    logic [c_iw-1:0] w_arb_idx;
    logic [c_iw-1:0] w_unused_ptr;
    logic [NREQ-1:0] w_grant;
    logic [c_iw-1:0] w_sel;
    logic [NREQ-1:0] r_pend;
    logic [DW-1:0]   r_hold;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (w_arb_req),
        .grant     (w_arb_grant),
        .grant_idx (w_arb_idx),
        .ptr       (w_unused_ptr)
    );

`ifdef RAMARB_PRIO0_EN
    // Hiding all requests from the round-robin core while requester 0 is
    // valid keeps its pointer frozen, so a priority grant never moves it.
    assign w_arb_req = req_valid[0] ? '0 : req_valid;
    assign w_grant   = req_valid[0] ? NREQ'(1) : w_arb_grant;
    assign w_sel     = req_valid[0] ? '0 : w_arb_idx;
`else
    assign w_arb_req = req_valid;
    assign w_grant   = w_arb_grant;
    assign w_sel     = w_arb_idx;
`endif

    // Nothing is granted or driven to the RAM while reset is asserted.
    assign req_ready = rst_n ? w_grant : '0;

    always_comb begin
        ram_addr = '0;
        ram_we   = 1'b0;
        ram_din  = '0;
        if (rst_n && (|w_grant)) begin
            ram_addr = req_addr[int'(w_sel)*AW +: AW];
            ram_we   = req_we[w_sel];
            ram_din  = req_wdata[int'(w_sel)*DW +: DW];
        end
    end

    // r_pend marks which requester's read data appears on ram_qout in the
    // next cycle; r_hold keeps the last delivered data between responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend <= '0;
            r_hold <= '0;
        end else begin
            r_pend <= w_grant & ~req_we;
            if (|r_pend) begin
                r_hold <= ram_qout;
            end
        end
    end

    assign rsp_valid = r_pend;
    assign rsp_rdata = (|r_pend) ? ram_qout : r_hold;

endmodule : ram_rr_arbiter
`default_nettype wire

// File: doc/ram_rr_arbiter.md
Name: ram_rr_arbiter

Overview:
- Shares one single-port, read-first, 1-cycle-registered-read RAM (DW x WORDS) between NREQ requesters.
- Round-robin grant with a per-requester valid/ready request channel and a per-requester read-response strobe.
- Sits between client engines and the RAM instance; drives the RAM's clk-domain addr/we/din and consumes its qout.

Parameters:
- NREQ, 2, number of requesters (2..8).
- DW, 8, data width.
- WORDS, 256, RAM depth; AW = $clog2(WORDS) is derived locally.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  request pending, one bit per requester.
- req_ready  output  NREQ  grant; a transfer occurs when valid&&ready.
- req_we  input  NREQ  1 = write, 0 = read.
- req_addr  input  NREQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  input  NREQ*DW  packed write data; requester i at [i*DW +: DW].
- rsp_valid  output  NREQ  one-hot read-data strobe.
- rsp_rdata  output  DW  read data, valid only while any rsp_valid bit is set.
- ram_addr  output  AW  to RAM addr.
- ram_we  output  1  to RAM we.
- ram_din  output  DW  to RAM din.
- ram_qout  input  DW  from RAM qout; registered, 1-cycle latency.

Behaviour:
- Reset (async assert): rsp_valid=0, rsp_rdata=0, last-grant pointer=NREQ-1, pending-read register cleared.
- Also during reset: req_ready=0, ram_we=0, ram_addr=0, ram_din=0, each forced combinationally while rst_n=0.
- Grant: combinational, at most one bit of req_ready set per cycle.
  - Search order starts at (ptr+1) mod NREQ, wraps, and takes the first requester with valid=1.
  - No valid bit set -> req_ready=0, ram_we=0, ram_addr=0, ram_din=0.
- Pointer update: on each cycle with a grant, ptr <= granted index. No grant -> ptr holds.
- RAM drive: same cycle as the grant.
  - ram_addr = granted address.
  - ram_we = granted req_we.
  - ram_din = granted wdata.
- Read response: a read granted in cycle T gives rsp_valid[i]=1 and rsp_rdata=ram_qout in cycle T+1, for exactly one cycle.
  - Implemented as a registered one-hot "pending" vector.
  - rsp_rdata is held at its last value when no response is due.
- Writes produce no response.
- Requester rules: after asserting valid, payload stays stable until ready. Back-to-back transfers by the same requester are allowed.
- Fairness: a requester holding valid continuously is granted within NREQ cycles. Throughput is one access per cycle.
- Ordering: per-requester accesses complete in grant order. A write at T followed by a read of the same address at T+1 or later returns the new data.
- Reset mid-operation: a read granted in the cycle rst_n falls never produces rsp_valid. The first grant after release goes to requester 0 if it is valid.
- Single-requester NREQ edge: the pointer always points at itself. Every valid is granted.

Optional Feature:
- Macro RAMARB_PRIO0_EN.
- Defined: requester 0 is high priority; whenever req_valid[0]=1 it is granted regardless of ptr.
  - Requesters 1..NREQ-1 round-robin among themselves.
  - A grant to requester 0 does not update ptr.
  - The fairness bound applies only while req_valid[0]=0.
- Undefined: plain round-robin over all NREQ as above.

Decomposition:
- Package ram_arb_pkg:
  - function onehot_to_idx (one-hot vector -> index, max width 8).
  - function rr_pick (request vector, pointer -> one-hot grant).
- Sub-module rr_arbiter #(N):
  - Ports: clk, rst_n, req[N], grant[N] (combinational), grant_idx, pointer register.
  - Reused for any future shared resource.
- ram_rr_arbiter contains the payload mux, the pending-read register and the response logic.

Test Plan:
- Reset values: rst_n=0 with all req_valid=1 -> req_ready=0, rsp_valid=0, ram_we=0. Release -> first grant to requester 0.
- Round-robin: NREQ=2, both requesters continuously reading addr 8'h10 / 8'h20 -> grants alternate 0,1,0,1. rsp_valid alternates one cycle behind, with rdata = RAM contents.
- Write then read: req0 writes 8'hA5 to 8'h03, next cycle req0 reads 8'h03 -> rsp_valid[0] one cycle later, rsp_rdata=8'hA5.
- Mixed contention: req1 writes 8'h5A to 8'h07 while req0 reads 8'h07 in the same cycle, ptr=1 -> req0 granted first and reads the old value; req1 writes next; a re-read returns 8'h5A.
- Reset mid-read: pull rst_n low in the cycle after a read grant -> rsp_valid never asserts, ptr returns to NREQ-1.
- With RAMARB_PRIO0_EN, NREQ=3, all valid for 6 cycles -> requester 0 granted every cycle. Then drop req0 -> grants go 1,2,1,2.
